// File: rtl/jtcps1_vram_arb.sv
// Three-port VRAM read arbiter for the CPS1 video path.
// Scroll, object and palette each own a one-word read cache; on a miss the
// requester competes round-robin for the single shared VRAM read port.
module jtcps1_vram_arb (
  input  logic        rst,
  input  logic        clk,
  // scroll
  input  logic [17:1] vram1_addr,
  input  logic        vram1_cs,
  output logic [15:0] vram1_data,
  output logic        vram1_ok,
  // objects
  input  logic [17:1] vram_obj_addr,
  input  logic        vram_obj_cs,
  output logic [15:0] vram_obj_data,
  output logic        vram_obj_ok,
  // palette
  input  logic [17:1] vram_pal_addr,
  input  logic        vram_pal_cs,
  output logic [15:0] vram_pal_data,
  output logic        vram_pal_ok,
  // shared VRAM port
  output logic [17:1] mem_addr,
  output logic        mem_cs,
  input  logic [15:0] mem_data,
  input  logic        mem_ok
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] IDX_SCR = 2'd0;
  localparam logic [1:0] IDX_OBJ = 2'd1;
  localparam logic [1:0] IDX_PAL = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [17:1] w_addr [3];
  logic [2:0]  w_cs;
  logic [2:0]  w_ok;
  logic [2:0]  w_pend;

  logic [15:0] r_data  [3];
  logic [17:1] r_tag   [3];
  logic [2:0]  r_valid;

  logic [1:0]  r_grant;
  logic [1:0]  r_last;
  logic [17:1] r_mem_addr;
  logic        r_mem_cs;

  logic [1:0]  w_grant_nxt;
  logic [1:0]  w_last_nxt;
  logic [17:1] w_mem_addr_nxt;
  logic        w_mem_cs_nxt;
  logic        w_fill;

  logic        w_found;
  logic [1:0]  w_pick;
  logic [1:0]  w_scan;

  // Wrap-around successor of a requester index (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == IDX_PAL) ? IDX_SCR : i + 2'd1;
  endfunction

  assign w_addr[IDX_SCR] = vram1_addr;
  assign w_addr[IDX_OBJ] = vram_obj_addr;
  assign w_addr[IDX_PAL] = vram_pal_addr;
  assign w_cs            = {vram_pal_cs, vram_obj_cs, vram1_cs};

  // Cache hit: requested address matches the valid tag; a miss is pending.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ok[i] = w_cs[i] & r_valid[i] & (r_tag[i] == w_addr[i]);
    end
    w_pend = w_cs & ~w_ok;
  end

  // Round-robin search for a pending requester, starting after the last grant.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    w_found = 1'b0;
    w_pick  = IDX_SCR;
    w_scan  = next_idx(r_last);
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_pend[w_scan]) begin
        w_found = 1'b1;
        w_pick  = w_scan;
      end
      w_scan = next_idx(w_scan);
    end
  end

  // Next-state and next-output logic of the two-state arbiter.
  always_comb begin
    w_state_nxt    = r_state;
    w_mem_cs_nxt   = r_mem_cs;
    w_mem_addr_nxt = r_mem_addr;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last;
    w_fill         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A stray mem_ok here is deliberately ignored.
        w_mem_cs_nxt = 1'b0;
        if (w_found) begin
          w_state_nxt    = ST_BUSY;
          w_mem_cs_nxt   = 1'b1;
          w_mem_addr_nxt = w_addr[w_pick];
          w_grant_nxt    = w_pick;
          w_last_nxt     = w_pick;
        end
      end
      ST_BUSY: begin
        // Address and request hold until the memory answers, even if the
        // requester has since dropped cs or moved its address.
        if (mem_ok) begin
          w_fill       = 1'b1;
          w_mem_cs_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Shared-port request registers and arbitration bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_cs   <= 1'b0;
      r_mem_addr <= '0;
      r_grant    <= IDX_SCR;
      r_last     <= IDX_PAL;
    end else begin
      r_mem_cs   <= w_mem_cs_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
    end
  end

  // Per-requester cache fill from the answered transfer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the caches are only three words, and a cleared valid bit alone is
    // not enough: data and tags must read as zero straight out of reset.
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_valid <= '0;
    end else if (w_fill) begin
      r_data[r_grant]  <= mem_data;
      r_tag[r_grant]   <= r_mem_addr;
      r_valid[r_grant] <= 1'b1;
    end
  end

  assign mem_cs        = r_mem_cs;
  assign mem_addr      = r_mem_addr;

  assign vram1_data    = r_data[IDX_SCR];
  assign vram_obj_data = r_data[IDX_OBJ];
  assign vram_pal_data = r_data[IDX_PAL];
  assign vram1_ok      = w_ok[IDX_SCR];
  assign vram_obj_ok   = w_ok[IDX_OBJ];
  assign vram_pal_ok   = w_ok[IDX_PAL];

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Self-checking bench for jtcps1_vram_arb: a memory responder answers each
// fetch after a programmable latency and checks it against a queue of
// expected fetch addresses filled by the stimulus.
module tb_jtcps1_vram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [17:1] addr [3];
  logic [2:0]  cs;
  logic [15:0] data0, data1, data2;
  logic        ok0, ok1, ok2;
  logic [15:0] data [3];
  logic [2:0]  ok;

  logic [17:1] mem_addr;
  logic        mem_cs;
  logic [15:0] mem_data;
  logic        mem_ok;

  // responder control (written by the main thread only)
  logic        resp_en  = 1'b1;
  logic        stray_ok = 1'b0;
  int          lat      = 2;

  // responder state (written by the responder only)
  logic        resp_busy;
  int          resp_cnt;
  logic [17:1] resp_rec;
  int          n_fetch = 0;

  logic [17:1] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  assign data[0] = data0;
  assign data[1] = data1;
  assign data[2] = data2;
  assign ok      = {ok2, ok1, ok0};

  jtcps1_vram_arb dut (
    .rst           (rst),
    .clk           (clk),
    .vram1_addr    (addr[0]),
    .vram1_cs      (cs[0]),
    .vram1_data    (data0),
    .vram1_ok      (ok0),
    .vram_obj_addr (addr[1]),
    .vram_obj_cs   (cs[1]),
    .vram_obj_data (data1),
    .vram_obj_ok   (ok1),
    .vram_pal_addr (addr[2]),
    .vram_pal_cs   (cs[2]),
    .vram_pal_data (data2),
    .vram_pal_ok   (ok2),
    .mem_addr      (mem_addr),
    .mem_cs        (mem_cs),
    .mem_data      (mem_data),
    .mem_ok        (mem_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents model: a fixed scramble of the word address.
  function automatic logic [15:0] data_of(input logic [17:1] a);
    return a[16:1] ^ 16'hBFEF ^ {a[17], 15'd0};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    cs  = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_ok(input int i, input int budget, input string tag);
    int t;
    t = 0;
    while (!ok[i] && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(ok[i]), 1);
  endtask

  task automatic wait_fetch(input int target, input int budget, input string tag);
    int t;
    t = 0;
    while (n_fetch < target && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(n_fetch), 32'(target));
  endtask

  // Memory responder: acts on the falling edge, answers after lat cycles.
  initial begin
    mem_ok    = 1'b0;
    mem_data  = '0;
    resp_busy = 1'b0;
    resp_cnt  = 0;
    resp_rec  = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        resp_busy = 1'b0;
        mem_ok    = stray_ok;
        mem_data  = 16'hDEAD;
      end else if (mem_ok) begin
        mem_ok = 1'b0;
        check("cs_gap", 32'(mem_cs), 0);
      end else if (resp_busy) begin
        check("mem_hold", 32'({mem_cs, mem_addr}), 32'({1'b1, resp_rec}));
        resp_cnt--;
        if (resp_cnt <= 0) begin
          mem_ok    = 1'b1;
          mem_data  = data_of(resp_rec);
          resp_busy = 1'b0;
        end
      end else if (mem_cs) begin
        resp_rec = mem_addr;
        n_fetch++;
        if (exp_q.size() == 0) check("sb_pop", 32'(exp_q.size()), 1);
        else                   check("fetch_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
        resp_cnt = lat - 1;
        if (resp_cnt <= 0) begin
          mem_ok   = 1'b1;
          mem_data = data_of(resp_rec);
        end else begin
          resp_busy = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int t_ok [3];
    int fcnt [2];
    int t;

    cs = '0;
    for (int i = 0; i < 3; i++) addr[i] = '0;

    // ---- reset values (probe with cs high at address 0 = reset tag) ----
    #2 rst = 1'b1;
    cs = 3'b111;
    #1;
    check("rst_mem_cs", 32'(mem_cs), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_ok", 32'(ok), 0);
    step();
    check("rst_ok_hold", 32'(ok), 0);
    for (int i = 0; i < 3; i++) check("rst_data", 32'(data[i]), 0);
    cs  = '0;
    rst = 1'b0;
    step();

    // ---- single object request, exact latency ----
    lat = 3;
    exp_q.push_back(17'h00100);
    addr[1] = 17'h00100;
    cs[1]   = 1'b1;
    step();
    check("single_cs", 32'(mem_cs), 1);
    check("single_addr", 32'(mem_addr), 32'h100);
    step();
    step();
    check("single_ok_early", 32'(ok[1]), 0);
    step();
    check("single_ok", 32'(ok[1]), 1);
    check("single_data", 32'(data[1]), 32'hBEEF);
    check("single_cs_off", 32'(mem_cs), 0);
    cs[1] = 1'b0;
    step();

    // ---- simultaneous requests after reset ----
    do_reset();
    lat     = 2;
    addr[0] = 17'h00A00;
    addr[1] = 17'h0B000;
    addr[2] = 17'h1C000;
    for (int i = 0; i < 3; i++) exp_q.push_back(addr[i]);
    cs = 3'b111;
    t_ok = '{-1, -1, -1};
    for (int c = 0; c < 60 && (t_ok[0] < 0 || t_ok[1] < 0 || t_ok[2] < 0); c++) begin
      for (int i = 0; i < 3; i++) if (ok[i] && t_ok[i] < 0) t_ok[i] = c;
      step();
    end
    check("sim_order", 32'((t_ok[0] >= 0) && (t_ok[0] < t_ok[1]) && (t_ok[1] < t_ok[2])), 1);
    for (int i = 0; i < 3; i++) check("sim_data", 32'(data[i]), 32'(data_of(addr[i])));
    check("sim_sb_empty", 32'(exp_q.size()), 0);
    cs = '0;
    step();

    // ---- palette cache hit, then neighbouring-address miss ----
    exp_q.push_back(17'h1F000);
    addr[2] = 17'h1F000;
    cs[2]   = 1'b1;
    wait_ok(2, 20, "hit_fill_ok");
    check("hit_fill_data", 32'(data[2]), 32'(data_of(17'h1F000)));
    cs[2] = 1'b0;
    step();
    cs[2] = 1'b1;
    #1;
    check("hit_ok", 32'(ok[2]), 1);
    f0 = n_fetch;
    repeat (4) step();
    check("hit_nofetch", 32'(n_fetch), 32'(f0));
    cs[2] = 1'b0;
    step();
    addr[2] = 17'h1F001;
    cs[2]   = 1'b1;
    #1;
    check("miss_ok", 32'(ok[2]), 0);
    exp_q.push_back(17'h1F001);
    wait_ok(2, 20, "miss_fill_ok");
    check("miss_data", 32'(data[2]), 32'(data_of(17'h1F001)));
    cs[2] = 1'b0;
    step();

    // ---- address change while the scroll fetch is in flight ----
    lat = 4;
    f0  = n_fetch;
    exp_q.push_back(17'h00010);
    exp_q.push_back(17'h00020);
    addr[0] = 17'h00010;
    cs[0]   = 1'b1;
    wait_fetch(f0 + 1, 10, "chg_granted");
    addr[0] = 17'h00020;
    wait_ok(0, 40, "chg_ok");
    check("chg_fetches", 32'(n_fetch), 32'(f0 + 2));
    check("chg_data", 32'(data[0]), 32'(data_of(17'h00020)));
    cs[0] = 1'b0;
    step();

    // ---- reset while busy, stray mem_ok after release ----
    lat = 10;
    f0  = n_fetch;
    exp_q.push_back(17'h00300);
    addr[1] = 17'h00300;
    cs[1]   = 1'b1;
    wait_fetch(f0 + 1, 10, "rstb_granted");
    step();
    resp_en = 1'b0;
    rst     = 1'b1;
    cs      = '0;
    #1;
    check("rstb_cs", 32'(mem_cs), 0);
    step();
    rst      = 1'b0;
    stray_ok = 1'b1;
    step();
    stray_ok = 1'b0;
    step();
    step();
    resp_en = 1'b1;
    for (int i = 0; i < 3; i++) addr[i] = '0;
    cs = 3'b111;
    #1;
    check("rstb_nowrite_ok", 32'(ok), 0);
    for (int i = 0; i < 3; i++) check("rstb_nowrite_data", 32'(data[i]), 0);
    lat = 2;
    for (int i = 0; i < 3; i++) exp_q.push_back(17'h0);
    wait_ok(0, 20, "rstb_scr_ok");
    check("rstb_scr_first", 32'(ok[2:1]), 0);
    wait_ok(1, 20, "rstb_obj_ok");
    check("rstb_obj_second", 32'(ok[2]), 0);
    wait_ok(2, 20, "rstb_pal_ok");
    for (int i = 0; i < 3; i++) check("rstb_data", 32'(data[i]), 32'(data_of(17'h0)));
    cs = '0;
    step();

    // ---- fairness: scroll and object continuously pending ----
    do_reset();
    lat = 1;
    for (int k = 0; k < 50; k++) begin
      exp_q.push_back(17'h08000 + 17'(k));
      exp_q.push_back(17'h10000 + 17'(k));
    end
    addr[0] = 17'h08000;
    addr[1] = 17'h10000;
    cs      = 3'b011;
    fcnt    = '{0, 0};
    t       = 0;
    while ((fcnt[0] < 50 || fcnt[1] < 50) && t < 2000) begin
      for (int i = 0; i < 2; i++) begin
        if (cs[i] && ok[i]) begin
          fcnt[i]++;
          addr[i] = addr[i] + 17'd1;
          if (fcnt[i] == 50) cs[i] = 1'b0;
        end
      end
      step();
      t++;
    end
    check("fair_scr_grants", 32'(fcnt[0]), 50);
    check("fair_obj_grants", 32'(fcnt[1]), 50);
    cs = '0;
    repeat (3) step();

    check("sb_final", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
